// File: rtl/if_id_stall_responder_pkg.sv
// Shared IF/ID pipeline definitions: word width, NOP encoding, reset PC and
// the stall-responder FSM state encoding.
package if_id_stall_responder_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    FLUSHED = 2'd2
  } pipeState_e;

endpackage

// File: rtl/if_id_stall_responder_if.sv
// Bundle between hazard/fetch logic (master) and the IF/ID stall responder (slave).
interface if_id_stall_responder_if #(
  parameter int CNT_W = 16
);
  import if_id_stall_responder_pkg::*;

  logic              stallSignal;
  logic              flush;
  logic [WORD_W-1:0] branch_target;
  logic [WORD_W-1:0] instr_in;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] IF_ID_instr;
  logic [WORD_W-1:0] IF_ID_pc4;
  logic              IF_ID_valid;
  logic              id_ex_bubble;
  logic              stall_active;
  logic [CNT_W-1:0]  stall_cycles;
  logic              stall_timeout;

  modport master (
    output stallSignal, flush, branch_target, instr_in,
    input  pc, IF_ID_instr, IF_ID_pc4, IF_ID_valid, id_ex_bubble,
           stall_active, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallSignal, flush, branch_target, instr_in,
    output pc, IF_ID_instr, IF_ID_pc4, IF_ID_valid, id_ex_bubble,
           stall_active, stall_cycles, stall_timeout
  );

endinterface

// File: rtl/if_id_stall_responder_stall_monitor.sv
// Stall statistics: consecutive-stall run length, total stalled cycles and a
// sticky timeout flag for a stall that never releases.
module if_id_stall_responder_stall_monitor #(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallHit,
  output logic [CNT_W-1:0] stallCycles,
  output logic             stallTimeout
);

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

  logic [RUN_W-1:0] runLenReg, runLenNext;
  logic [CNT_W-1:0] cyclesReg, cyclesNext;
  logic             timeoutReg, timeoutNext;

  always_comb begin
    runLenNext  = '0;
    cyclesNext  = cyclesReg;
    timeoutNext = timeoutReg;
    if (stallHit) begin
      runLenNext = (runLenReg == RUN_SAT) ? runLenReg : runLenReg + 1'b1;
      // the increment that takes the run past MAX_STALL raises the flag
      if (runLenReg >= RUN_LIMIT) timeoutNext = 1'b1;
      if (cyclesReg != '1) cyclesNext = cyclesReg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runLenReg  <= '0;
      cyclesReg  <= '0;
      timeoutReg <= 1'b0;
    end else begin
      runLenReg  <= runLenNext;
      cyclesReg  <= cyclesNext;
      timeoutReg <= timeoutNext;
    end
  end

  assign stallCycles  = cyclesReg;
  assign stallTimeout = timeoutReg;

endmodule

// File: rtl/if_id_stall_responder.sv
// Load-use hazard consumer: owns the PC, the IF/ID register and the ID/EX
// bubble select; priority is flush over stall over normal advance.
module if_id_stall_responder
  import if_id_stall_responder_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                MAX_STALL = 4,
  parameter int                CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  if_id_stall_responder_if.slave  bus
);

  logic [WORD_W-1:0] pcReg, pcNext;
  logic [WORD_W-1:0] instrReg, instrNext;
  logic [WORD_W-1:0] pc4Reg, pc4Next;
  logic              validReg, validNext;
  logic [WORD_W-1:0] pcPlus4;
  logic              stallHit;
  logic              stallActive;
  logic              bubble;
  pipeState_e        stateReg, stateNext;

  assign pcPlus4  = pcReg + 32'd4;
  assign stallHit = bus.stallSignal & ~bus.flush;

  always_comb begin
    pcNext    = pcReg;
    instrNext = instrReg;
    pc4Next   = pc4Reg;
    validNext = validReg;
    if (bus.flush) begin
      // squash the younger fetch; pc4 is left as-is since valid marks the bubble
      pcNext    = bus.branch_target;
      instrNext = NOP_INSTR;
      validNext = 1'b0;
    end else if (!bus.stallSignal) begin
      pcNext    = pcPlus4;
      instrNext = bus.instr_in;
      pc4Next   = pcPlus4;
      validNext = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg    <= RESET_PC;
      instrReg <= NOP_INSTR;
      pc4Reg   <= '0;
      validReg <= 1'b0;
    end else begin
      pcReg    <= pcNext;
      instrReg <= instrNext;
      pc4Reg   <= pc4Next;
      validReg <= validNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= RUN;
    else        stateReg <= stateNext;
  end

  // every state reacts to the same inputs, so the decode collapses to priority
  always_comb begin
    stateNext = RUN;
    case (stateReg)
      RUN, HOLD, FLUSHED: begin
        if (bus.flush)      stateNext = FLUSHED;
        else if (stallHit)  stateNext = HOLD;
        else                stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    stallActive = (stateReg == HOLD);
    bubble      = bus.flush | bus.stallSignal;
  end

  if_id_stall_responder_stall_monitor #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_monitor (
    .clk          (clk),
    .rst_n        (rst_n),
    .stallHit     (stallHit),
    .stallCycles  (bus.stall_cycles),
    .stallTimeout (bus.stall_timeout)
  );

  assign bus.pc           = pcReg;
  assign bus.IF_ID_instr  = instrReg;
  assign bus.IF_ID_pc4    = pc4Reg;
  assign bus.IF_ID_valid  = validReg;
  assign bus.id_ex_bubble = bubble;
  assign bus.stall_active = stallActive;

endmodule
